// File: rtl/input_debouncer.sv
// Synchronizes a raw asynchronous line and accepts a level change only after it
// has held for STABLE_CYCLES synchronized clocks; emits one-cycle rise/fall pulses.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RESET_VAL     = 1'b0,
  parameter int unsigned CNT_WIDTH     = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   sync_q;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   data_q, data_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_q = chain_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      state_q <= STABLE;
      cnt_q   <= '0;
      data_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], data_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A return to the current level aborts qualification; otherwise count until acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q == data_q) begin
      cnt_d   = '0;
      state_d = STABLE;
    end else if (cnt_q == CNT_LAST) begin
      data_d  = sync_q;
      cnt_d   = '0;
      state_d = STABLE;
      rise_d  = sync_q;
      fall_d  = ~sync_q;
    end else begin
      cnt_d   = cnt_q + CNT_WIDTH'(1);
      state_d = PENDING;
    end
  end

  always_comb begin
    data_out = data_q;
    rise     = rise_q;
    fall     = fall_q;
    busy     = (state_q == PENDING);
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: four parameterisations share one stimulus stream and
// are compared against a sample-history model every cycle, plus directed tables.
module tb_input_debouncer;

  logic clk;
  logic rst;
  logic data_in;
  logic dout [4];
  logic rise [4];
  logic fall [4];
  logic busy [4];

  int checks   = 0;
  int failures = 0;

  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_VAL(1'b0)) u0 (
    .clk(clk), .rst(rst), .data_in(data_in),
    .data_out(dout[0]), .rise(rise[0]), .fall(fall[0]), .busy(busy[0]));
  input_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .RESET_VAL(1'b0)) u1 (
    .clk(clk), .rst(rst), .data_in(data_in),
    .data_out(dout[1]), .rise(rise[1]), .fall(fall[1]), .busy(busy[1]));
  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(8), .RESET_VAL(1'b0)) u2 (
    .clk(clk), .rst(rst), .data_in(data_in),
    .data_out(dout[2]), .rise(rise[2]), .fall(fall[2]), .busy(busy[2]));
  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_VAL(1'b1)) u3 (
    .clk(clk), .rst(rst), .data_in(data_in),
    .data_out(dout[3]), .rise(rise[3]), .fall(fall[3]), .busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ss_of(int i);
    case (i)
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int sc_of(int i);
    case (i)
      1:       return 1;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic bit rv_of(int i);
    return (i == 3);
  endfunction

  // Model: raw samples taken at each edge since reset; the synchronized value after
  // edge k is the sample from edge k-SS+1; a change is accepted at edge n when the
  // synchronized values seen before edges n-SC+1..n all differ from the output.
  bit din_hist[$];
  int n_edges;
  bit m_out [4];
  bit m_rise[4];
  bit m_fall[4];
  bit m_busy[4];
  bit u1_busy_seen;

  function automatic bit sync_at(int i, int k);
    int idx;
    idx = k - ss_of(i) + 1;
    if (idx < 1) return rv_of(i);
    return din_hist[idx-1];
  endfunction

  function automatic void model_reset();
    din_hist.delete();
    n_edges = 0;
    for (int i = 0; i < 4; i++) begin
      m_out[i]  = rv_of(i);
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge(bit r, bit d);
    bit acc;
    if (r) begin
      model_reset();
      return;
    end
    din_hist.push_back(d);
    n_edges++;
    for (int i = 0; i < 4; i++) begin
      acc = 1'b1;
      for (int j = 1; j <= sc_of(i); j++)
        if (sync_at(i, n_edges - j) == m_out[i]) acc = 1'b0;
      if (acc) begin
        m_rise[i] = ~m_out[i];
        m_fall[i] = m_out[i];
        m_out[i]  = ~m_out[i];
        m_busy[i] = 1'b0;
      end else begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        m_busy[i] = (sync_at(i, n_edges - 1) != m_out[i]);
      end
    end
  endfunction

  function automatic void chk(string nm, int i, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t: got %b expected %b", nm, i, $time, got, exp);
    end
  endfunction

  function automatic void chk_int(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endfunction

  function automatic void compare_all();
    for (int i = 0; i < 4; i++) begin
      chk("model_out",  i, dout[i], m_out[i]);
      chk("model_rise", i, rise[i], m_rise[i]);
      chk("model_fall", i, fall[i], m_fall[i]);
      chk("model_busy", i, busy[i], m_busy[i]);
    end
    if (busy[1]) u1_busy_seen = 1'b1;
  endfunction

  task automatic cycle(input logic r, input logic d);
    rst     = r;
    data_in = d;
    @(posedge clk);
    model_edge(r, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic settle(input logic d, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, d);
  endtask

  typedef struct {
    logic r;
    logic d;
    logic e_out;
    logic e_rise;
    logic e_fall;
    logic e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic d, logic o, logic ri, logic f, logic b);
    vec_t v;
    v.r = r; v.d = d; v.e_out = o; v.e_rise = ri; v.e_fall = f; v.e_busy = b;
    tbl.push_back(v);
  endfunction

  initial begin
    int lat[3];
    int rise_cnt;
    int e;
    logic lvl;
    int hold;

    u1_busy_seen = 1'b0;
    rst     = 1'b1;
    data_in = 1'b1;
    model_reset();
    #2;
    chk("rst_out", 0, dout[0], 1'b0);
    chk("rst_out", 3, dout[3], 1'b1);
    chk("rst_busy", 0, busy[0], 1'b0);

    // Reset held 3 clocks with data_in=1, then release: rise at edge 6.
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 1); add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0); add(0, 1, 1, 0, 0, 0);
    // Clean falling step.
    add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1); add(0, 0, 1, 0, 0, 1); add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
    // Glitch of 3 clocks: counter reaches STABLE_CYCLES-1 but is never accepted.
    add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
    // Bounce train 1,0,1,0,1 then steady 1: single rise 6 edges after final 0->1.
    add(0, 1, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 1); add(0, 1, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0); add(0, 1, 1, 0, 0, 0);

    foreach (tbl[k]) begin
      cycle(tbl[k].r, tbl[k].d);
      chk("tbl_out",  k, dout[0], tbl[k].e_out);
      chk("tbl_rise", k, rise[0], tbl[k].e_rise);
      chk("tbl_fall", k, fall[0], tbl[k].e_fall);
      chk("tbl_busy", k, busy[0], tbl[k].e_busy);
    end

    // Reset in the middle of qualification must take effect immediately.
    settle(1'b0, 14);
    cycle(1'b0, 1'b1); cycle(1'b0, 1'b1); cycle(1'b0, 1'b1);
    chk("midq_busy_before", 0, busy[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("midq_rst_out", 0, dout[0], 1'b0);
    chk("midq_rst_busy", 0, busy[0], 1'b0);
    @(negedge clk);
    cycle(1'b1, 1'b1);
    lat[0] = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b1);
      if (rise[0] && lat[0] < 0) lat[0] = k;
    end
    chk_int("midq_relatency", lat[0], 6);

    // Step latency across parameterisations.
    settle(1'b0, 14);
    for (int i = 0; i < 3; i++) lat[i] = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
        if (rise[i] && lat[i] < 0) lat[i] = k;
    end
    chk_int("lat_ss2_sc4", lat[0], 6);
    chk_int("lat_ss3_sc1", lat[1], 4);
    chk_int("lat_ss2_sc8", lat[2], 10);

    // Seven-clock glitch against STABLE_CYCLES=8 must be rejected.
    settle(1'b0, 14);
    rise_cnt = 0;
    e = 0;
    for (int k = 0; k < 21; k++) begin
      cycle(1'b0, (k < 7) ? 1'b1 : 1'b0);
      if (rise[2]) rise_cnt++;
      if (busy[2]) e++;
    end
    chk_int("glitch7_rises", rise_cnt, 0);
    chk_int("glitch7_busy_cycles", e, 7);
    chk("glitch7_out", 2, dout[2], 1'b0);

    // Random bouncy stimulus with occasional resets.
    lvl = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        hold = $urandom_range(1, 2);
        for (int h = 0; h < hold; h++) cycle(1'b1, lvl);
      end
      if ($urandom_range(0, 3) == 0) begin
        cycle(1'b0, ~lvl);
      end else begin
        lvl  = ~lvl;
        hold = $urandom_range(1, 12);
        for (int h = 0; h < hold; h++) cycle(1'b0, lvl);
      end
    end

    chk("u1_busy_never", 1, u1_busy_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
